// File: rtl/port_icap_ctrl_if.sv
// Byte-stream and ICAP signal bundle for port_icap_ctrl.
// slave = the controller, master = the port/ICAP side driving it.
interface port_icap_ctrl_if #(
    parameter int ICAP_WIDTH = 32
);
    logic                  en_wr;
    logic                  en_rd;
    logic [7:0]            in_data;
    logic                  in_sof;
    logic                  in_eof;
    logic                  in_src_rdy;
    logic                  in_dst_rdy;
    logic [7:0]            out_data;
    logic                  out_sof;
    logic                  out_eof;
    logic                  out_src_rdy;
    logic                  out_dst_rdy;
    logic                  icap_ce_n;
    logic                  icap_write_n;
    logic [ICAP_WIDTH-1:0] icap_i;
    logic [ICAP_WIDTH-1:0] icap_o;
    logic                  icap_busy;
    logic                  rd_overrun;

    modport slave (
        input  en_wr, en_rd, in_data, in_sof, in_eof, in_src_rdy, out_dst_rdy, icap_o, icap_busy,
        output in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy, icap_ce_n, icap_write_n,
               icap_i, rd_overrun
    );

    modport master (
        output en_wr, en_rd, in_data, in_sof, in_eof, in_src_rdy, out_dst_rdy, icap_o, icap_busy,
        input  in_dst_rdy, out_data, out_sof, out_eof, out_src_rdy, icap_ce_n, icap_write_n,
               icap_i, rd_overrun
    );
endinterface

// File: rtl/port_icap_ctrl.sv
// ICAP controller for the PATLPP byte port: packs write frames into ICAP words, serialises readback.
// Define PORT_ICAP_WR_ACK_EN to answer each write frame with a 2-byte word-count ack.
module port_icap_ctrl #(
    parameter int ICAP_WIDTH = 32,
    parameter int FIFO_AW    = 11
) (
    input  logic            clk,
    input  logic            rst,
    port_icap_ctrl_if.slave bus
);
    localparam int BPW = ICAP_WIDTH / 8;
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] BPW_C = (FIFO_AW+1)'(BPW);
    localparam logic [2:0] BPW_B = 3'(BPW);

    typedef enum logic [2:0] {IDLE, WR_PACK, WR_ISSUE, RD_HDR, RD_RUN, WR_ACK} state_e;

    // ICAP bit order is reversed inside every byte on both data buses.
    function automatic logic [ICAP_WIDTH-1:0] brev(input logic [ICAP_WIDTH-1:0] w);
        for (int i = 0; i < ICAP_WIDTH; i++) brev[i] = w[(i & ~7) + 7 - (i & 7)];
    endfunction

    state_e                state_q, state_d;
    logic [ICAP_WIDTH-1:0] word_q, word_d, ser_q, ser_d;
    logic [2:0]            bcnt_q, bcnt_d, ser_cnt_q, ser_cnt_d;
    logic                  weof_q, weof_d, ser_last_q, ser_last_d, sof_pend_q, sof_pend_d;
    logic                  ovr_q, ovr_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            hb_q, hb_d;
    logic [FIFO_AW:0]      fcnt_q, fcnt_d;
    logic [FIFO_AW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
    logic [9:0]            mem_q [DEPTH];

    logic                  dst_rdy, ce_n, write_n, issue_hold;
    logic                  in_acc, cap, wr_fire, push, pop, empty;
    logic [9:0]            push_data;
    logic [FIFO_AW:0]      free;
    logic [ICAP_WIDTH-1:0] pk, rev_o;
    logic [15:0]           req_cnt;
    logic                  unused_in_sof;

`ifdef PORT_ICAP_WR_ACK_EN
    localparam logic [FIFO_AW:0] TWO_C = (FIFO_AW+1)'(2);
    logic [15:0] wr_words_q, wr_words_d, wr_inc;
    assign wr_inc     = wr_words_q + 16'd1;
    // The final word must leave room for the ack frame it triggers.
    assign issue_hold = weof_q && (free < TWO_C);
`else
    assign issue_hold = 1'b0;
`endif

    assign unused_in_sof = bus.in_sof;
    assign empty   = (fcnt_q == '0);
    assign free    = DEPTH_C - fcnt_q;
    assign in_acc  = bus.in_src_rdy & dst_rdy;
    assign cap     = (state_q == RD_RUN) & ~ce_n & ~bus.icap_busy;
    assign wr_fire = (state_q == WR_ISSUE) & ~ce_n & ~bus.icap_busy;
    assign pop     = ~empty & bus.out_dst_rdy;
    assign rev_o   = brev(bus.icap_o);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            ser_q      <= '0;
            bcnt_q     <= '0;
            ser_cnt_q  <= '0;
            weof_q     <= 1'b0;
            ser_last_q <= 1'b0;
            sof_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
            hb_q       <= '0;
            fcnt_q     <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
`ifdef PORT_ICAP_WR_ACK_EN
            wr_words_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            ser_q      <= ser_d;
            bcnt_q     <= bcnt_d;
            ser_cnt_q  <= ser_cnt_d;
            weof_q     <= weof_d;
            ser_last_q <= ser_last_d;
            sof_pend_q <= sof_pend_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
            hb_q       <= hb_d;
            fcnt_q     <= fcnt_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
`ifdef PORT_ICAP_WR_ACK_EN
            wr_words_q <= wr_words_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        ser_d      = ser_q;
        bcnt_d     = bcnt_q;
        ser_cnt_d  = ser_cnt_q;
        weof_d     = weof_q;
        ser_last_d = ser_last_q;
        sof_pend_d = sof_pend_q;
        ovr_d      = ovr_q;
        cnt_d      = cnt_q;
        hb_d       = hb_q;
        push       = 1'b0;
        push_data  = '0;
        pk         = (word_q << 8) | ICAP_WIDTH'(bus.in_data);
        req_cnt    = (hb_q == 2'd1) ? {cnt_q[15:8], bus.in_data} : cnt_q;
`ifdef PORT_ICAP_WR_ACK_EN
        wr_words_d = wr_words_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.en_wr && bus.in_src_rdy) begin
                    state_d = WR_PACK;
                    bcnt_d  = '0;
                end else if (bus.en_rd && bus.in_src_rdy) begin
                    state_d = RD_HDR;
                    hb_d    = '0;
                    cnt_d   = '0;
                end
            end
            WR_PACK: if (in_acc) begin
                if ((bcnt_q + 3'd1 == BPW_B) || bus.in_eof) begin
                    // Left-align a short final word so the missing low bytes are zero.
                    word_d  = pk << (8 * (BPW - 1 - int'(bcnt_q)));
                    bcnt_d  = '0;
                    weof_d  = bus.in_eof;
                    state_d = WR_ISSUE;
                end else begin
                    word_d = pk;
                    bcnt_d = bcnt_q + 3'd1;
                end
            end
            WR_ISSUE: if (wr_fire) begin
`ifdef PORT_ICAP_WR_ACK_EN
                wr_words_d = wr_inc;
                if (weof_q) begin
                    push      = 1'b1;
                    push_data = {2'b10, wr_inc[15:8]};
                    state_d   = WR_ACK;
                end else begin
                    state_d = WR_PACK;
                end
`else
                state_d = weof_q ? IDLE : WR_PACK;
`endif
            end
`ifdef PORT_ICAP_WR_ACK_EN
            WR_ACK: begin
                push       = 1'b1;
                push_data  = {2'b01, wr_words_q[7:0]};
                wr_words_d = '0;
                state_d    = IDLE;
            end
`endif
            RD_HDR: if (in_acc) begin
                if (hb_q == 2'd0) cnt_d[15:8] = bus.in_data;
                if (hb_q == 2'd1) cnt_d[7:0] = bus.in_data;
                if (hb_q != 2'd2) hb_d = hb_q + 2'd1;
                if (bus.in_eof) begin
                    if (hb_q == 2'd0) begin
                        state_d = IDLE;
                    end else begin
                        if (!empty) ovr_d = 1'b1;
                        if (req_cnt == 16'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = RD_RUN;
                            sof_pend_d = 1'b1;
                        end
                    end
                end
            end
            RD_RUN: begin
                // The MSB byte goes straight to the FIFO; the rest drain from the serialiser.
                if (cap) begin
                    push       = 1'b1;
                    push_data  = {sof_pend_q, (cnt_q == 16'd1) && (BPW == 1), rev_o[ICAP_WIDTH-1 -: 8]};
                    sof_pend_d = 1'b0;
                    cnt_d      = cnt_q - 16'd1;
                    ser_d      = rev_o << 8;
                    ser_cnt_d  = BPW_B - 3'd1;
                    ser_last_d = (cnt_q == 16'd1);
                end else if (ser_cnt_q != 3'd0) begin
                    push      = 1'b1;
                    push_data = {1'b0, ser_last_q && (ser_cnt_q == 3'd1), ser_q[ICAP_WIDTH-1 -: 8]};
                    ser_d     = ser_q << 8;
                    ser_cnt_d = ser_cnt_q - 3'd1;
                end else if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fcnt_d = fcnt_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop) rptr_d = rptr_q + 1'b1;
        if (push && !pop) fcnt_d = fcnt_q + 1'b1;
        if (!push && pop) fcnt_d = fcnt_q - 1'b1;
    end

    always_comb begin
        dst_rdy = 1'b0;
        ce_n    = 1'b1;
        write_n = 1'b1;
        case (state_q)
            WR_PACK: begin
                dst_rdy = 1'b1;
                write_n = 1'b0;
            end
            WR_ISSUE: begin
                write_n = 1'b0;
                ce_n    = issue_hold;
            end
            RD_HDR: dst_rdy = 1'b1;
            RD_RUN: ce_n = !((ser_cnt_q == 3'd0) && (cnt_q != 16'd0) && (free >= BPW_C));
            default: ;
        endcase
    end

    assign bus.in_dst_rdy   = dst_rdy;
    assign bus.icap_ce_n    = ce_n;
    assign bus.icap_write_n = write_n;
    assign bus.icap_i       = brev(word_q);
    assign bus.rd_overrun   = ovr_q;
    assign bus.out_src_rdy  = ~empty;
    assign bus.out_data     = empty ? 8'h00 : mem_q[rptr_q][7:0];
    assign bus.out_eof      = ~empty & mem_q[rptr_q][8];
    assign bus.out_sof      = ~empty & mem_q[rptr_q][9];
endmodule
